// File: rtl/divider.sv
// ============================================================================
// Module   : divider
// Purpose  : Iterative 32-bit integer divider (radix-2 restoring) for the
//            RISC-V M-extension execute stage. Returns quotient and remainder
//            together with RISC-V semantics for divide-by-zero and signed
//            overflow.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   rising-edge clock
//   rstn       in   1   synchronous active-low reset
//   in_valid   in   1   operands valid
//   in_ready   out  1   divider idle and able to accept
//   A          in   32  dividend
//   B          in   32  divisor
//   sign       in   1   1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   out_valid  out  1   Q/R valid
//   out_ready  in   1   consumer takes result
//   Q          out  32  quotient
//   R          out  32  remainder
// ----------------------------------------------------------------------------
// Configuration
//   DIV_SPECIAL_FAST_EN : when defined, divide-by-zero and signed overflow
//                         skip the iteration and reach DONE on the accept
//                         edge. Results are bit-identical either way.
// ============================================================================
`default_nettype none

module divider (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Q,
  output logic [31:0] R
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [31:0] dvd_q,   dvd_d;   // dividend shifter, doubles as quotient
  logic [31:0] rem_q,   rem_d;   // partial remainder
  logic [31:0] dsr_q,   dsr_d;   // divisor magnitude
  logic [31:0] q_q,     q_d;
  logic [31:0] r_q,     r_d;
  logic        qneg_q,  qneg_d;
  logic        rneg_q,  rneg_d;
  logic        dz_q,    dz_d;

  logic [31:0] a_mag_w;
  logic [31:0] b_mag_w;
  logic [32:0] shift_w;
  logic        ge_w;
  logic [31:0] diff_w;

  // Operand magnitudes; 0x80000000 maps onto itself, which is the correct
  // unsigned magnitude.
  assign a_mag_w = (sign && A[31]) ? (~A + 32'd1) : A;
  assign b_mag_w = (sign && B[31]) ? (~B + 32'd1) : B;

  // Trial subtraction. shift_w can exceed 32 bits when the divisor is large,
  // so the compare uses all 33 bits; when it succeeds the difference is
  // smaller than the divisor and fits in 32 bits.
  assign shift_w = {rem_q, dvd_q[31]};
  assign ge_w    = (shift_w >= {1'b0, dsr_q});
  assign diff_w  = shift_w[31:0] - dsr_q;

`ifdef DIV_SPECIAL_FAST_EN
  logic ovf_w;
  assign ovf_w = sign && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    q_d     = q_q;
    r_d     = r_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d   = a_mag_w;
          dsr_d   = b_mag_w;
          rem_d   = 32'd0;
          qneg_d  = sign & (A[31] ^ B[31]);
          rneg_d  = sign & A[31];
          dz_d    = (B == 32'd0);
          cnt_d   = 6'd0;
          state_d = S_CALC;
`ifdef DIV_SPECIAL_FAST_EN
          if (B == 32'd0) begin
            q_d     = 32'hFFFF_FFFF;
            r_d     = A;
            state_d = S_DONE;
          end else if (ovf_w) begin
            q_d     = 32'h8000_0000;
            r_d     = 32'd0;
            state_d = S_DONE;
          end
`endif
        end
      end

      S_CALC: begin
        if (ge_w) begin
          rem_d = diff_w;
          dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
          rem_d = shift_w[31:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // With a zero divisor every step succeeds, so rem ends as |A| and
        // the sign fix-up restores R = A in both modes.
        if (dz_q) begin
          q_d = 32'hFFFF_FFFF;
        end else begin
          q_d = qneg_q ? (~dvd_q + 32'd1) : dvd_q;
        end
        r_d     = rneg_q ? (~rem_q + 32'd1) : rem_q;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      dvd_q   <= 32'd0;
      rem_q   <= 32'd0;
      dsr_q   <= 32'd0;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Q         = q_q;
  assign R         = r_q;

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ============================================================================
// Module   : tb_divider
// Purpose  : Self-checking bench for divider. Directed scenarios plus a
//            randomized run, all compared against a plain-arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_divider;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic [31:0] r;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  divider dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .sign     (sgn),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Q        (q),
    .R        (r)
  );

  // ---------------- reference model (RISC-V division rules) ----------------
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  input logic s,
                                  output logic [31:0] eq, output logic [31:0] er);
    if (y == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = x;
    end else if (!s) begin
      eq = x / y;
      er = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      eq = 32'h8000_0000;
      er = 32'd0;
    end else begin
      eq = $signed(x) / $signed(y);
      er = $signed(x) % $signed(y);
    end
  endfunction

  // Expected number of clock edges after the accept edge until out_valid is
  // seen high: 33 normally; with the fast path the result is already valid
  // right after the accept edge.
  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y,
                                 input logic s);
`ifdef DIV_SPECIAL_FAST_EN
    if (y == 32'd0 || (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))
      return 0;
`endif
    return 33;
  endfunction

  // ---------------- drivers (no checking inside) ----------------
  // Called at posedge+1; returns at accept-edge+1 with in_valid dropped.
  task automatic start(input logic [31:0] x, input logic [31:0] y, input logic s);
    int n;
    a = x; b = y; sgn = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                       output logic [31:0] oq, output logic [31:0] orr, output int lat);
    start(x, y, s);
    wait_done(lat);
    oq = q; orr = r;
    take();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sgn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else passed++;
    total++; if ({q, r} !== 64'd0) $display("FAIL reset_QR: got Q=%h R=%h want 0/0", q, r); else passed++;
    rstn = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] oq, orr; int lat;
    do_op(32'd100, 32'd7, 1'b0, oq, orr, lat);
    total++; if (oq !== 32'd14) $display("FAIL udiv_Q: got %h want %h", oq, 32'd14); else passed++;
    total++; if (orr !== 32'd2) $display("FAIL udiv_R: got %h want %h", orr, 32'd2); else passed++;
    total++; if (lat !== 33) $display("FAIL udiv_latency: got %0d want 33", lat); else passed++;
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, oq, orr, lat);
    total++; if ({oq, orr} !== {32'hFFFF_FFFF, 32'd0}) $display("FAIL udiv_max: got Q=%h R=%h want ffffffff/0", oq, orr); else passed++;
  endtask

  task automatic test_signed();
    logic [31:0] oq, orr; int lat;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, oq, orr, lat);
    total++; if ({oq, orr} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) $display("FAIL sdiv_neg_dividend: got Q=%h R=%h want fffffffd/ffffffff", oq, orr); else passed++;
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, oq, orr, lat);
    total++; if ({oq, orr} !== {32'hFFFF_FFFD, 32'd1}) $display("FAIL sdiv_neg_divisor: got Q=%h R=%h want fffffffd/1", oq, orr); else passed++;
    total++; if (lat !== 33) $display("FAIL sdiv_latency: got %0d want 33", lat); else passed++;
  endtask

  task automatic test_div_zero();
    logic [31:0] oq, orr; int lat;
    do_op(32'h8000_0005, 32'd0, 1'b1, oq, orr, lat);
    total++; if ({oq, orr} !== {32'hFFFF_FFFF, 32'h8000_0005}) $display("FAIL dz_signed: got Q=%h R=%h want ffffffff/80000005", oq, orr); else passed++;
    total++; if (lat !== exp_lat(32'h8000_0005, 32'd0, 1'b1)) $display("FAIL dz_latency: got %0d want %0d", lat, exp_lat(32'h8000_0005, 32'd0, 1'b1)); else passed++;
    do_op(32'h8000_0005, 32'd0, 1'b0, oq, orr, lat);
    total++; if ({oq, orr} !== {32'hFFFF_FFFF, 32'h8000_0005}) $display("FAIL dz_unsigned: got Q=%h R=%h want ffffffff/80000005", oq, orr); else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] oq, orr; int lat;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, oq, orr, lat);
    total++; if ({oq, orr} !== {32'h8000_0000, 32'd0}) $display("FAIL ovf: got Q=%h R=%h want 80000000/0", oq, orr); else passed++;
    total++; if (lat !== exp_lat(32'h8000_0000, 32'hFFFF_FFFF, 1'b1)) $display("FAIL ovf_latency: got %0d want %0d", lat, exp_lat(32'h8000_0000, 32'hFFFF_FFFF, 1'b1)); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] q0, r0; int lat; int bad;
    start(32'd1000, 32'd33, 1'b0);
    wait_done(lat);
    q0 = q; r0 = r;
    total++; if ({q0, r0} !== {32'd30, 32'd10}) $display("FAIL bp_result: got Q=%h R=%h want 1e/a", q0, r0); else passed++;
    // A new request held during DONE must be ignored until DONE->IDLE.
    a = 32'd100; b = 32'd1; sgn = 1'b0; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (q !== q0 || r !== r0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    total++; if (bad !== 0) $display("FAIL bp_hold: %0d bad cycles, last Q=%h R=%h in_ready=%0b out_valid=%0b want Q=%h R=%h 0 1", bad, q, r, in_ready, out_valid, q0, r0); else passed++;
    take();
    total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release: got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_held_accept: in_ready=%0b want 0", in_ready); else passed++;
    wait_done(lat);
    total++; if ({q, r} !== {32'd100, 32'd0} || lat !== 33) $display("FAIL bp_second: got Q=%h R=%h lat=%0d want 64/0 lat 33", q, r, lat); else passed++;
    take();
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] oq, orr; int lat;
    start(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL midreset_flags: got out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); else passed++;
    do_op(32'd100, 32'd7, 1'b0, oq, orr, lat);
    total++; if ({oq, orr} !== {32'd14, 32'd2}) $display("FAIL midreset_followup: got Q=%h R=%h want e/2", oq, orr); else passed++;
  endtask

  task automatic test_back_to_back();
    int n; int lat;
    out_ready = 1'b1;
    start(32'd50, 32'd5, 1'b0);
    a = 32'd51; b = 32'd5; sgn = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;   // second accept
    in_valid = 1'b0;
    // accept-to-accept spacing in edges
    total++; if (n + 1 !== 35) $display("FAIL b2b_spacing: got %0d want 35", n + 1); else passed++;
    wait_done(lat);
    total++; if ({q, r} !== {32'd10, 32'd1}) $display("FAIL b2b_result: got Q=%h R=%h want a/1", q, r); else passed++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] x, y, eq, er, oq, orr; logic s; int lat; int sel;
    for (int i = 0; i < 40; i++) begin
      x = $urandom; s = 1'($urandom_range(0, 1)); sel = $urandom_range(0, 7);
      case (sel)
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = $urandom_range(1, 15);
        3: y = -($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      ref_div(x, y, s, eq, er);
      do_op(x, y, s, oq, orr, lat);
      total++;
      if (oq !== eq || orr !== er || lat !== exp_lat(x, y, s))
        $display("FAIL random[%0d] A=%h B=%h sign=%0b: got Q=%h R=%h lat=%0d want Q=%h R=%h lat=%0d",
                 i, x, y, s, oq, orr, lat, eq, er, exp_lat(x, y, s));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
